// File: rtl/risc_v_mem_arbiter.sv
// Round-robin sequencer sharing the core's single-port unified memory between
// instruction fetch (read-only) and data access, with a fixed per-access wait count.
module risc_v_mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;

    logic              grant_valid;
    logic              grant_owner;
    logic              in_access;
    logic              last_cycle;

    // On a tie the requester that did not win last time gets the memory.
    always_comb begin
        grant_valid = if_req | dm_req;
        grant_owner = OWN_IF;
        if (if_req && dm_req) begin
            grant_owner = ~last_grant;
        end else if (dm_req) begin
            grant_owner = OWN_DM;
        end
    end

    assign last_cycle = (state == S_ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_DM;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= 4'd0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_owner;
                        last_grant <= grant_owner;
                        if (grant_owner == OWN_DM) begin
                            addr_q  <= dm_addr;
                            wdata_q <= dm_wdata;
                            we_q    <= dm_we;
                        end else begin
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                        end
                        cnt   <= CNT_LOAD;
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!we_q) begin
                            if (owner == OWN_DM) begin
                                dm_rdata <= mem_dout;
                            end else begin
                                if_rdata <= mem_dout;
                            end
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are gated by rst so an aborted write never reaches memory and no ack escapes.
    assign in_access = (state == S_ACCESS) && !rst;
    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_din   = in_access ? wdata_q : '0;
    assign mem_we    = in_access && last_cycle && we_q;
    assign if_ack    = (state == S_DONE) && (owner == OWN_IF) && !rst;
    assign dm_ack    = (state == S_DONE) && (owner == OWN_DM) && !rst;
    assign busy      = (state != S_IDLE) && !rst;

endmodule

// File: tb/tb_risc_v_mem_arbiter.sv
// Bench for risc_v_mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-timing model of the arbiter.
module tb_risc_v_mem_arbiter;

    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic        if_ack, dm_ack, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_din, mem_dout;

    logic        rst_b = 1'b1;
    logic        if_req_b = 1'b0;
    logic [31:0] if_addr_b = '0;
    logic        if_ack_b, dm_ack_b, mem_we_b, busy_b;
    logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_din_b, mem_dout_b;

    risc_v_mem_arbiter #(.LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .busy(busy)
    );

    risc_v_mem_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_b (
        .clk(clk), .rst(rst_b),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_ack(dm_ack_b), .dm_rdata(dm_rdata_b),
        .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b), .mem_dout(mem_dout_b),
        .busy(busy_b)
    );

    function automatic logic [31:0] seed_word(input int i);
        if (i == 2) return 32'h0050_0093;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Word-addressed memories; addr[1:0] is ignored, 16 words alias across the address space.
    logic [31:0] mem_a [16];
    bit          seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= seed_word(i);
            seeded <= 1'b1;
        end else if (mem_we) begin
            mem_a[mem_addr[5:2]] <= mem_din;
        end
    end
    assign mem_dout   = mem_a[mem_addr[5:2]];
    assign mem_dout_b = seed_word(int'(mem_addr_b[5:2]));

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a granted transaction occupies offsets 1..L (memory driven,
    // write on offset L) and acks at offset L+1, measured from its grant cycle.
    initial begin : model
        bit          act = 1'b0;
        bit          own = 1'b0;
        bit          mwe = 1'b0;
        bit          last = 1'b1;
        bit          rd_skip = 1'b1;
        int          start = 0;
        int          off = 0;
        logic [31:0] maddr = '0, mwd = '0, eif = '0, edm = '0;
        logic [31:0] ref_mem [16];
        logic        e_busy, e_we, e_ifa, e_dma;
        logic [31:0] e_addr, e_din;
        for (int i = 0; i < 16; i++) ref_mem[i] = seed_word(i);
        forever begin
            @(negedge clk);
            e_busy = 1'b0; e_we = 1'b0; e_ifa = 1'b0; e_dma = 1'b0;
            e_addr = '0; e_din = '0;
            if (!rst && act) begin
                off    = cyc - start;
                e_busy = 1'b1;
                if (off <= L) begin
                    e_addr = maddr;
                    e_din  = mwd;
                    e_we   = mwe && (off == L);
                end else begin
                    e_ifa = !own;
                    e_dma = own;
                end
            end
            check_output("busy", 32'(busy), 32'(e_busy));
            check_output("mem_we", 32'(mem_we), 32'(e_we));
            check_output("mem_addr", mem_addr, e_addr);
            check_output("mem_din", mem_din, e_din);
            check_output("if_ack", 32'(if_ack), 32'(e_ifa));
            check_output("dm_ack", 32'(dm_ack), 32'(e_dma));
            if (!rst && !rd_skip) begin
                check_output("if_rdata", if_rdata, eif);
                check_output("dm_rdata", dm_rdata, edm);
            end
            if (rst) begin
                act = 1'b0; last = 1'b1; eif = '0; edm = '0; rd_skip = 1'b1;
            end else begin
                rd_skip = 1'b0;
                if (act) begin
                    if (off == L) begin
                        if (mwe) ref_mem[maddr[5:2]] = mwd;
                        else if (own) edm = ref_mem[maddr[5:2]];
                        else eif = ref_mem[maddr[5:2]];
                    end
                    if (off == L + 1) act = 1'b0;
                end else if (if_req || dm_req) begin
                    own   = (if_req && dm_req) ? !last : dm_req;
                    last  = own;
                    act   = 1'b1;
                    start = cyc;
                    maddr = own ? dm_addr : if_addr;
                    mwd   = own ? dm_wdata : 32'h0;
                    mwe   = own ? dm_we : 1'b0;
                end
            end
        end
    end

    task automatic apply_stimulus(input bit dm, input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, output int lat,
                                  output int we_cycles, output int we_pos);
        @(posedge clk); #1;
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = -1; we_cycles = 0; we_pos = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cycles++;
                we_pos = k;
                check_output("write_addr", mem_addr, addr);
            end
            if (dm ? dm_ack : if_ack) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    int lat, wec, wep, n, both, bad;
    int at [3];
    int who [3];
    logic [31:0] dat [2];

    initial begin
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'h0);
        check_output("reset_if_rdata", if_rdata, 32'h0);
        check_output("reset_dm_rdata", dm_rdata, 32'h0);

        apply_stimulus(1'b0, 1'b0, 32'h8, 32'h0, lat, wec, wep);
        check_output("if_read_latency", 32'(lat), 32'd3);
        check_output("if_read_data", if_rdata, 32'h0050_0093);
        check_output("if_read_no_we", 32'(wec), 32'd0);

        apply_stimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, wec, wep);
        check_output("dm_write_latency", 32'(lat), 32'd3);
        check_output("dm_write_we_cycles", 32'(wec), 32'd1);
        check_output("dm_write_we_pos", 32'(wep), 32'd2);
        check_output("dm_write_rdata_kept", dm_rdata, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, lat, wec, wep);
        check_output("dm_readback", dm_rdata, 32'hDEAD_BEEF);

        // Both requesters raised together straight out of reset and held.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
        n = 0; both = 0;
        for (int i = 0; i < 3; i++) begin at[i] = -1; who[i] = -1; end
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            if (if_ack && dm_ack) both++;
            if (if_ack || dm_ack) begin
                who[n] = dm_ack ? 1 : 0;
                at[n]  = k;
                n++;
            end
        end
        @(posedge clk); #1; if_req = 1'b0; dm_req = 1'b0;
        check_output("rr_both_acks", 32'(both), 32'd0);
        check_output("rr_grant0", 32'(who[0]), 32'd0);
        check_output("rr_grant1", 32'(who[1]), 32'd1);
        check_output("rr_grant2", 32'(who[2]), 32'd0);
        check_output("rr_ack0_at", 32'(at[0]), 32'd3);
        check_output("rr_ack1_at", 32'(at[1]), 32'd7);
        check_output("rr_ack2_at", 32'(at[2]), 32'd11);
        check_output("rr_if_data", if_rdata, 32'h1000_0000);
        check_output("rr_dm_data", dm_rdata, 32'hDEAD_BEEF);

        // Reset in the first ACCESS cycle of a write aborts it.
        @(posedge clk); #1; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h14; dm_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1; rst = 1'b1;
        bad = 0;
        @(negedge clk); if (mem_we || dm_ack) bad++;
        @(posedge clk); #1; dm_req = 1'b0;
        @(negedge clk); if (mem_we || dm_ack) bad++;
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) begin
            @(negedge clk); if (mem_we || dm_ack) bad++;
        end
        check_output("abort_no_we_ack", 32'(bad), 32'd0);
        check_output("abort_busy", 32'(busy), 32'h0);
        check_output("abort_if_rdata", if_rdata, 32'h0);
        check_output("abort_dm_rdata", dm_rdata, 32'h0);
        check_output("abort_mem_kept", mem_a[5], 32'h1505_0505);

        // LATENCY=1 instance: back-to-back fetches, next request the cycle after ack.
        @(posedge clk); #1; if_req_b = 1'b1; if_addr_b = 32'h0;
        n = 0; bad = 0; at[0] = -1; at[1] = -1; dat[0] = '0; dat[1] = '0;
        for (int k = 0; k < 30 && n < 2; k++) begin
            @(negedge clk);
            if (mem_we_b || dm_ack_b) bad++;
            if (if_ack_b) begin
                at[n]  = k;
                dat[n] = if_rdata_b;
                n++;
                @(posedge clk); #1;
                if (n == 2) if_req_b = 1'b0;
                else if_addr_b = 32'h4;
            end
        end
        if_req_b = 1'b0;
        check_output("l1_ack0_at", 32'(at[0]), 32'd2);
        check_output("l1_ack1_at", 32'(at[1]), 32'd5);
        check_output("l1_data0", dat[0], 32'h1000_0000);
        check_output("l1_data1", dat[1], 32'h1101_0101);
        check_output("l1_no_we_dm_ack", 32'(bad), 32'd0);
        @(negedge clk);
        check_output("l1_idle_busy", 32'(busy_b), 32'h0);
        check_output("l1_dm_rdata", dm_rdata_b, 32'h0);
        check_output("l1_mem_din", mem_din_b, 32'h0);

        begin : random_phase
            bit if_seen = 1'b0, dm_seen = 1'b0;
            int if_wait = 0, dm_wait = 0, max_wait = 0, acks = 0;
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk); #1;
                rst = ($urandom_range(0, 199) == 0);
                if (!(if_req && !if_seen)) begin
                    if_req  = ($urandom_range(0, 2) != 0);
                    if_addr = $urandom;
                end
                if (!(dm_req && !dm_seen)) begin
                    dm_req   = ($urandom_range(0, 2) != 0);
                    dm_we    = $urandom_range(0, 1) != 0;
                    dm_addr  = $urandom;
                    dm_wdata = $urandom;
                end
                @(negedge clk);
                if_seen = if_ack;
                dm_seen = dm_ack;
                if (if_ack) acks++;
                if (dm_ack) acks++;
                if_wait = (if_req && !if_ack && !rst) ? if_wait + 1 : 0;
                dm_wait = (dm_req && !dm_ack && !rst) ? dm_wait + 1 : 0;
                if (if_wait > max_wait) max_wait = if_wait;
                if (dm_wait > max_wait) max_wait = dm_wait;
            end
            @(posedge clk); #1; rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
            checks++;
            if (max_wait > 16) begin
                failures++;
                $display("[TB] FAIL random_max_wait actual=%0d required<=16", max_wait);
            end
            checks++;
            if (acks < 100) begin
                failures++;
                $display("[TB] FAIL random_ack_count actual=%0d required>=100", acks);
            end
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
